cla_serial_add_ctrl: RTL and testbench



---
 rtl/cla_serial_add_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cla_serial_add_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice stepped over the nibbles, LSB first.
// Optional signed-overflow output enabled by defining CLA_ADD_OVF_EN.

module cla (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // All carries are flattened lookahead terms, none ripple through another.
    assign carry[0] = cin_i;
    assign carry[1] = gen[0] | (prop[0] & cin_i);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin_i);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & cin_i);
    assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & cin_i);

    assign sum_o  = prop ^ carry[3:0];
    assign cout_o = carry[4];
endmodule

module cla_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
`ifdef CLA_ADD_OVF_EN
    output logic             ovf_o,
`endif
    output logic             busy_o
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic [3:0] sliceA;
    logic [3:0] sliceB;
    logic [3:0] sliceSum;
    logic       sliceCout;

    assign sliceA = a_q[4*idx_q +: 4];
    assign sliceB = b_q[4*idx_q +: 4];

    cla u_cla (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

`ifdef CLA_ADD_OVF_EN
    logic ovf_q, ovf_d;
    logic msbCarryIn;

    // The carry into the slice's top bit is recovered from its inputs and sum bit.
    assign msbCarryIn = sliceA[3] ^ sliceB[3] ^ sliceSum[3];
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef CLA_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[4*idx_q +: 4] = sliceSum;
                carry_d             = sliceCout;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
`ifdef CLA_ADD_OVF_EN
                    ovf_d   = msbCarryIn ^ sliceCout;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef CLA_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef CLA_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum_o       = sum_q;
    assign cout_o      = carry_q;
`ifdef CLA_ADD_OVF_EN
    assign ovf_o       = ovf_q;
`endif
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// Directed self-checking bench for cla_serial_add_ctrl at WIDTH=16.
// Overflow checks are compiled in when CLA_ADD_OVF_EN is defined.

module tb_cla_serial_add_ctrl;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_ADD_OVF_EN
    logic             ovf;
`endif

    int testCount = 0;
    int failCount = 0;

    cla_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .sum_o       (sum),
        .cout_o      (cout),
`ifdef CLA_ADD_OVF_EN
        .ovf_o       (ovf),
`endif
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand set for exactly one edge; caller is in IDLE.
    task automatic applyStimulus(input logic [WIDTH-1:0] aVal, input logic [WIDTH-1:0] bVal, input logic cinVal);
        a       = aVal;
        b       = bVal;
        cin     = cinVal;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    // Counts cycles from acceptance (cycle 1 is right after the accepting edge) until out_valid.
    task automatic waitDone(input string tag);
        int cyc;
        cyc = 1;
        while (!outValid && cyc < 20) begin
            checkOutput({tag, "_inReadyLow"}, 32'(inReady), 32'd0);
            tick();
            cyc++;
        end
        checkOutput({tag, "_latency"}, 32'(cyc), 32'd5);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] expSum, input logic expCout, input logic expOvf);
        checkOutput({tag, "_outValid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "_sum"}, 32'(sum), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
`ifdef CLA_ADD_OVF_EN
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(expOvf));
`else
        if (expOvf !== 1'b0 && expOvf !== 1'b1) $display("[TB] note: bad expOvf in %s", tag);
`endif
    endtask

    task automatic releaseResult(input string tag);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checkOutput({tag, "_relOutValid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_relInReady"}, 32'(inReady), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        tick();
        tick();

        checkOutput("rst_inReady", 32'(inReady), 32'd1);
        checkOutput("rst_outValid", 32'(outValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_ADD_OVF_EN
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        applyStimulus(16'h1234, 16'h4321, 1'b0);
        checkOutput("basic_busy", 32'(busy), 32'd1);
        waitDone("basic");
        checkResult("basic", 16'h5555, 1'b0, 1'b0);
        checkOutput("basic_doneBusy", 32'(busy), 32'd1);
        releaseResult("basic");

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitDone("ripple");
        checkResult("ripple", 16'h0000, 1'b1, 1'b0);
        releaseResult("ripple");

        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        waitDone("posOvf");
        checkResult("posOvf", 16'h8000, 1'b0, 1'b1);
        releaseResult("posOvf");

        applyStimulus(16'h0000, 16'h0000, 1'b1);
        waitDone("cinOnly");
        checkResult("cinOnly", 16'h0001, 1'b0, 1'b0);
        releaseResult("cinOnly");

        // Backpressure: result held, in_valid pulses in DONE ignored.
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        waitDone("bp");
        for (int i = 0; i < 3; i++) begin
            a       = 16'h1111;
            b       = 16'h2222;
            inValid = 1'b1;
            tick();
            checkResult("bpHold", 16'h0001, 1'b1, 1'b1);
            checkOutput("bpHold_inReady", 32'(inReady), 32'd0);
        end
        inValid = 1'b0;
        releaseResult("bp");
        applyStimulus(16'h0102, 16'h0304, 1'b0);
        waitDone("afterBp");
        checkResult("afterBp", 16'h0406, 1'b0, 1'b0);
        releaseResult("afterBp");

        // Operand changes during RUN must not affect the result.
        applyStimulus(16'h0F0F, 16'h0101, 1'b0);
        a   = 16'hAAAA;
        b   = 16'h5555;
        cin = 1'b1;
        waitDone("opChange");
        checkResult("opChange", 16'h1010, 1'b0, 1'b0);
        releaseResult("opChange");

        // Reset in the middle of RUN discards the operation.
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midRst_inReady", 32'(inReady), 32'd1);
        checkOutput("midRst_outValid", 32'(outValid), 32'd0);
        checkOutput("midRst_busy", 32'(busy), 32'd0);
        checkOutput("midRst_sum", 32'(sum), 32'd0);
        checkOutput("midRst_cout", 32'(cout), 32'd0);
`ifdef CLA_ADD_OVF_EN
        checkOutput("midRst_ovf", 32'(ovf), 32'd0);
`endif
        applyStimulus(16'h0001, 16'h0001, 1'b0);
        waitDone("postRst");
        checkResult("postRst", 16'h0002, 1'b0, 1'b0);
        releaseResult("postRst");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
